// File: rtl/qmem_pkg.sv
// Shared definitions for the QMEM responder: FSM encodings and
// the byte-offset width helper used by the address decoder.
package qmem_pkg;

    // Responder FSM states (2-bit registered encoding).
    typedef enum logic [1:0] {
        QM_IDLE = 2'd0,
        QM_WAIT = 2'd1,
        QM_RESP = 2'd2
    } qm_state_e;

    // Number of low address bits that select a byte inside a word.
    function automatic int qm_offs_w(input int qsw);
        return (qsw > 1) ? $clog2(qsw) : 0;
    endfunction

    // Byte-offset width for the default 32-bit data path.
    localparam int QM_OFFS_W_DEF = 2;

endpackage

// File: rtl/qmem_ram_be.sv
// Single-port synchronous word RAM with per-byte write enables.
// Read data appears on dout the cycle after an enabled access
// (read-first on a write cycle).
module qmem_ram_be #(
    parameter int QSW = 4,
    parameter int IAW = 10,
    parameter int QDW = 8 * QSW
) (
    input  logic           clk,
    input  logic           en,
    input  logic [QSW-1:0] we,
    input  logic [IAW-1:0] adr,
    input  logic [QDW-1:0] din,
    output logic [QDW-1:0] dout
);

    logic [QDW-1:0] mem_q [2**IAW];
    logic [QDW-1:0] dout_q;

    // Enabled access: write the selected byte lanes, register the old word.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < QSW; i++) begin
                if (we[i]) begin
                    mem_q[adr][8*i +: 8] <= din[8*i +: 8];
                end
            end
            dout_q <= mem_q[adr];
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/qmem_slave_ram.sv
// QMEM responder terminating master requests into a local byte-writable
// RAM, with a programmable wait-state count sampled at request acceptance
// and an error response for addresses outside the RAM window.
//
// Handshake: the master raises qs_cs with we/sel/adr/dat_w and holds them
// stable until qs_ack or qs_err (one-cycle pulses, never both) is seen.
// A new request may be presented in the cycle after the response; cs still
// high during RESP is not treated as a request. Dropping cs while the
// responder is waiting aborts the transfer with no write and no response.
module qmem_slave_ram
    import qmem_pkg::*;
#(
    parameter int QAW   = 32,
    parameter int QDW   = 32,
    parameter int QSW   = QDW / 8,
    parameter int DEPTH = 1024,
    parameter int IAW   = $clog2(DEPTH),
    parameter int WW    = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [WW-1:0]  ws,
    input  logic           qs_cs,
    input  logic           qs_we,
    input  logic [QSW-1:0] qs_sel,
    input  logic [QAW-1:0] qs_adr,
    input  logic [QDW-1:0] qs_dat_w,
    output logic [QDW-1:0] qs_dat_r,
    output logic           qs_ack,
    output logic           qs_err,
    output logic           busy,
    output logic [1:0]     dbg_state
);

    localparam int OFFS = qm_offs_w(QSW);

    qm_state_e      state_q, state_d;
    logic [WW-1:0]  cnt_q, cnt_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic           rd_q, rd_d;

    logic [IAW-1:0] word_idx;
    logic           out_of_range;
    logic           resp_go;
    logic           ram_en;
    logic [QSW-1:0] ram_we;
    logic [QDW-1:0] ram_dout;
    logic           unused_adr;

    // Address decode: word index, window check; byte offset is ignored.
    assign word_idx     = qs_adr[IAW+OFFS-1:OFFS];
    assign out_of_range = |qs_adr[QAW-1:IAW+OFFS];
    assign unused_adr   = ^qs_adr[OFFS-1:0];

    // Last WAIT cycle with the request still asserted: response is decided.
    assign resp_go = (state_q == QM_WAIT) && qs_cs && (cnt_q == '0);

    // The RAM is touched only on the WAIT->RESP edge for in-range requests.
    assign ram_en = resp_go && !out_of_range;
    assign ram_we = qs_we ? qs_sel : '0;

    qmem_ram_be #(
        .QSW (QSW),
        .IAW (IAW),
        .QDW (QDW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .adr  (word_idx),
        .din  (qs_dat_w),
        .dout (ram_dout)
    );

    // Next-state and response decisions; defaults hold state, clear pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rd_d    = 1'b0;
        case (state_q)
            QM_IDLE: begin
                if (qs_cs) begin
                    state_d = QM_WAIT;
                    cnt_d   = ws;
                end
            end
            QM_WAIT: begin
                if (!qs_cs) begin
                    state_d = QM_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - WW'(1);
                end else begin
                    state_d = QM_RESP;
                    err_d   = out_of_range;
                    ack_d   = !out_of_range;
                    rd_d    = !out_of_range && !qs_we;
                end
            end
            QM_RESP: begin
                state_d = QM_IDLE;
            end
            default: begin
                state_d = QM_IDLE;
            end
        endcase
    end

    // State, wait counter and registered response flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= QM_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    // Read data is the RAM output word, gated to zero outside a read ack.
    assign qs_dat_r  = rd_q ? ram_dout : '0;
    assign qs_ack    = ack_q;
    assign qs_err    = err_q;
    assign busy      = (state_q != QM_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_qmem_slave_ram.sv
// Directed bench for qmem_slave_ram: a vector table of single transfers
// plus hand-written reset, abort and back-to-back sequences.
module tb_qmem_slave_ram;

    logic        clk;
    logic        rst;
    logic [2:0]  ws;
    logic        qs_cs;
    logic        qs_we;
    logic [3:0]  qs_sel;
    logic [31:0] qs_adr;
    logic [31:0] qs_dat_w;
    logic [31:0] qs_dat_r;
    logic        qs_ack;
    logic        qs_err;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    qmem_slave_ram dut (
        .clk       (clk),
        .rst       (rst),
        .ws        (ws),
        .qs_cs     (qs_cs),
        .qs_we     (qs_we),
        .qs_sel    (qs_sel),
        .qs_adr    (qs_adr),
        .qs_dat_w  (qs_dat_w),
        .qs_dat_r  (qs_dat_r),
        .qs_ack    (qs_ack),
        .qs_err    (qs_err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Response pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (qs_ack) ack_cnt++;
        if (qs_err) err_cnt++;
    end

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat_w;
        logic [2:0]  ws;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transfer from IDLE, checking latency, response and the
    // return of all response outputs to zero in the following cycle.
    task automatic do_xfer(input string tag, input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] dat_w,
                           input logic [2:0] wsv, input logic exp_err,
                           input logic [31:0] exp_dat);
        int lat;
        @(posedge clk); #1;
        ws       = wsv;
        qs_we    = we;
        qs_sel   = sel;
        qs_adr   = adr;
        qs_dat_w = dat_w;
        qs_cs    = 1'b1;
        lat      = 0;
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        while (!(qs_ack || qs_err) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) ws = ~wsv;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(lat), 32'(wsv) + 32'd2);
        check({tag, "_ack"}, 32'(qs_ack), 32'(!exp_err));
        check({tag, "_err"}, 32'(qs_err), 32'(exp_err));
        check({tag, "_dat_r"}, qs_dat_r, exp_dat);
        check({tag, "_resp_state"}, 32'(dbg_state), 32'd2);
        @(posedge clk); #1;
        qs_cs = 1'b0;
        @(negedge clk);
        check({tag, "_after_ack"}, 32'(qs_ack), 32'd0);
        check({tag, "_after_err"}, 32'(qs_err), 32'd0);
        check({tag, "_after_dat"}, qs_dat_r, 32'd0);
        check({tag, "_after_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int a0;
        int e0;
        int prev;
        int lat;

        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 3'd0, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000, 3'd0, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 4'h4, 32'h0000_0010, 32'h00AA_0000, 3'd3, 1'b0, 32'h0000_0000};
        vecs[3]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000, 3'd3, 1'b0, 32'hDEAA_BEEF};
        vecs[4]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h1234_5678, 3'd2, 1'b0, 32'h0000_0000};
        vecs[5]  = '{1'b0, 4'hF, 32'h0000_1000, 32'h0000_0000, 3'd2, 1'b1, 32'h0000_0000};
        vecs[6]  = '{1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 3'd1, 1'b1, 32'h0000_0000};
        vecs[7]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h0000_0000, 3'd1, 1'b0, 32'h1234_5678};
        vecs[8]  = '{1'b1, 4'hF, 32'h0000_0014, 32'h1122_3344, 3'd7, 1'b0, 32'h0000_0000};
        vecs[9]  = '{1'b1, 4'h3, 32'h0000_0014, 32'hCAFE_F00D, 3'd0, 1'b0, 32'h0000_0000};
        vecs[10] = '{1'b1, 4'h0, 32'h0000_0017, 32'hFFFF_FFFF, 3'd1, 1'b0, 32'h0000_0000};
        vecs[11] = '{1'b0, 4'hF, 32'h0000_0016, 32'h0000_0000, 3'd2, 1'b0, 32'h1122_F00D};
        vecs[12] = '{1'b0, 4'hF, 32'h8000_0014, 32'h0000_0000, 3'd0, 1'b1, 32'h0000_0000};
        vecs[13] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'hA5A5_A5A5, 3'd1, 1'b0, 32'h0000_0000};
        vecs[14] = '{1'b0, 4'hF, 32'h0000_0FFC, 32'h0000_0000, 3'd4, 1'b0, 32'hA5A5_A5A5};
        vecs[15] = '{1'b0, 4'hF, 32'h0000_0000, 32'h0000_0000, 3'd0, 1'b0, 32'h1234_5678};

        // Reset
        rst      = 1'b1;
        ws       = 3'd0;
        qs_cs    = 1'b0;
        qs_we    = 1'b0;
        qs_sel   = 4'h0;
        qs_adr   = 32'h0;
        qs_dat_w = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ack", 32'(qs_ack), 32'd0);
        check("rst_err", 32'(qs_err), 32'd0);
        check("rst_dat", qs_dat_r, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // Vector table
        for (int i = 0; i < 16; i++) begin
            do_xfer($sformatf("vec%0d", i), vecs[i].we, vecs[i].sel, vecs[i].adr,
                    vecs[i].dat_w, vecs[i].ws, vecs[i].exp_err, vecs[i].exp_dat);
        end

        // Reset in the middle of a pending write
        @(posedge clk); #1;
        ws = 3'd5; qs_we = 1'b1; qs_sel = 4'hF; qs_adr = 32'h10; qs_dat_w = 32'h0BAD_F00D;
        qs_cs = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_ack", 32'(qs_ack), 32'd0);
        check("midrst_err", 32'(qs_err), 32'd0);
        check("midrst_dat", qs_dat_r, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        qs_cs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_xfer("midrst_read", 1'b0, 4'hF, 32'h10, 32'h0, 3'd0, 1'b0, 32'hDEAA_BEEF);

        // Master abort after two WAIT cycles
        a0 = ack_cnt;
        e0 = err_cnt;
        @(posedge clk); #1;
        ws = 3'd4; qs_we = 1'b1; qs_sel = 4'hF; qs_adr = 32'h10; qs_dat_w = 32'h5555_5555;
        qs_cs = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        qs_cs = 1'b0;
        @(negedge clk);
        check("abort_busy_wait", 32'(busy), 32'd1);
        @(negedge clk);
        check("abort_busy_next", 32'(busy), 32'd0);
        repeat (8) @(negedge clk);
        check("abort_no_ack", 32'(ack_cnt - a0), 32'd0);
        check("abort_no_err", 32'(err_cnt - e0), 32'd0);
        do_xfer("abort_read", 1'b0, 4'hF, 32'h10, 32'h0, 3'd2, 1'b0, 32'hDEAA_BEEF);

        // Back-to-back reads with cs held high
        for (int i = 0; i < 8; i++) begin
            do_xfer($sformatf("b2b_fill%0d", i), 1'b1, 4'hF, 32'h40 + 32'(4 * i),
                    32'h0101_0101 * 32'(i + 1), 3'd0, 1'b0, 32'h0);
        end
        a0 = ack_cnt;
        e0 = err_cnt;
        prev = 0;
        @(posedge clk); #1;
        ws = 3'd1; qs_we = 1'b0; qs_sel = 4'hF; qs_dat_w = 32'h0;
        qs_cs = 1'b1;
        for (int i = 0; i < 8; i++) begin
            qs_adr = 32'h40 + 32'(4 * i);
            lat = 0;
            @(negedge clk);
            while (!qs_ack && lat < 20) begin
                @(posedge clk); #1;
                lat++;
                @(negedge clk);
            end
            check($sformatf("b2b%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("b2b%0d_dat", i), qs_dat_r, 32'h0101_0101 * 32'(i + 1));
            if (i > 0) check($sformatf("b2b%0d_spacing", i), 32'(cyc - prev), 32'd4);
            prev = cyc;
            @(posedge clk); #1;
        end
        qs_cs = 1'b0;
        repeat (8) @(negedge clk);
        check("b2b_ack_count", 32'(ack_cnt - a0), 32'd8);
        check("b2b_err_count", 32'(err_cnt - e0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/qmem_slave_ram.md
Name: qmem_slave_ram

Overview:
- QMEM responder (slave end of the QMEM bus) that terminates master requests into a local byte-writable word RAM.
- Inserts a runtime-programmable number of wait states before acknowledging.
- Flags accesses outside its address window with `qs_err`.
- Used as a target behind QMEM bridges/decoders and as the bus-level model for verifying QMEM masters and frequency converters.

Parameters:
- QAW, 32, address width (byte address)
- QDW, 32, data width
- QSW, QDW/8, byte-select width
- DEPTH, 1024, RAM depth in words (power of two)
- IAW, log2(DEPTH), word-index width
- WW, 3, wait-state count width

Ports:
- clk  in  1  single clock for the whole block
- rst  in  1  reset, asynchronous, active-high
- ws  in  WW  wait states inserted before response; sampled only on request acceptance
- qs_cs  in  1  chip-select
- qs_we  in  1  write enable
- qs_sel  in  QSW  byte select
- qs_adr  in  QAW  byte address
- qs_dat_w  in  QDW  write data
- qs_dat_r  out  QDW  read data, valid while qs_ack high
- qs_ack  out  1  acknowledge, one-cycle pulse
- qs_err  out  1  error, one-cycle pulse, mutually exclusive with qs_ack
- busy  out  1  high in WAIT or RESP

Behaviour:
- **Reset:** one clock; reset is asynchronous and active-high. Reset forces:
  - state IDLE, wait counter 0;
  - qs_ack=0, qs_err=0, qs_dat_r=0, busy=0.
  - RAM contents are not reset. Reset mid-transaction aborts it with no write and no response.
- **Protocol:** the master holds cs/we/sel/adr/dat_w stable until it sees ack or err. It may present a new request in the cycle after the response.
- **Address decode:**
  - word index = qs_adr[IAW+1:2] (for QSW=4; generally qs_adr[IAW+log2(QSW)-1 : log2(QSW)]);
  - out_of_range = |qs_adr[QAW-1 : IAW+log2(QSW)];
  - low byte-offset bits are ignored.
- **FSM (registered, 2-bit):**
  - **IDLE:** if qs_cs, load cnt<=ws and go to WAIT.
  - **WAIT:**
    - if !qs_cs (master abort): go to IDLE, no write, no response.
    - else if cnt!=0: cnt<=cnt-1.
    - else (cnt==0): go to RESP, registering the response below.
  - **RESP:** qs_ack or qs_err is high this cycle. Go to IDLE unconditionally; cs still high in RESP is not a new request.
- **Response registered on the WAIT→RESP edge:**
  - out_of_range: qs_err<=1, qs_dat_r<=0, no RAM write.
  - write in range: RAM lanes with qs_sel[i]=1 are written from qs_dat_w[8i+7:8i]; other lanes are unchanged. qs_ack<=1, qs_dat_r<=0. sel=0 is a legal no-op write that is still acked.
  - read in range: qs_dat_r<=RAM[index], qs_ack<=1.
- **Latency:** with cs first high in cycle N (state IDLE), ack/err is high in cycle N+2+ws. Back-to-back throughput is one transfer per ws+3 cycles.
- **Outputs after response:** qs_ack, qs_err and qs_dat_r return to 0 in the cycle after RESP.
- **ws handling:** changes to ws during WAIT do not affect the transfer in progress.
- **Read-after-write:** a read following a write to the same word returns the new data, because the write commits before the read's RESP.

Decomposition:
- Shared package qmem_pkg:
  - state encodings QM_IDLE=2'd0, QM_WAIT=2'd1, QM_RESP=2'd2;
  - helper constant for the byte-offset width log2(QSW).
- One sub-module: qmem_ram_be, a single-port synchronous RAM with per-byte write enables.
  - Ports: clk, en, we[QSW], adr[IAW], din, dout.
  - Keeps the RAM inferable separately from the FSM.

Test Plan:
- Reset: assert rst mid-WAIT (ws=5, write pending) → ack/err/dat_r/busy 0 immediately; a later read of that address returns the old value.
- ws=0: write 0xDEADBEEF to 0x10, sel=4'hF → ack in cycle N+2; read 0x10 → ack at N+2 with dat_r=0xDEADBEEF; ack is exactly one cycle wide.
- ws=3, byte write: sel=4'b0100, dat_w=0x00AA0000 to 0x10 → ack at N+5; read 0x10 → 0xDEAABEEF.
- Out of range (DEPTH=1024): read adr=0x00001000 → qs_err high one cycle at N+2+ws, qs_ack=0, dat_r=0; write to the same address leaves the aliased word 0x0 unchanged.
- Abort: ws=4, cs drops after 2 WAIT cycles → no ack/err, no write, busy low next cycle; a new request is then served normally.
- Back-to-back: cs held continuously with 8 sequential reads, ws=1 → exactly 8 acks spaced 4 cycles apart, each with correct data; no duplicate ack from cs staying high during RESP.
